// File: rtl/reg_cdc_req_sequencer.sv
// reg_cdc_req_sequencer: source-domain front end for a bank of register CDC slots.
// Takes one outstanding req/gnt request at a time and decodes it to a slot.
// It issues a single write or read pulse, waits for that slot's busy to drop,
// and then returns the slot read-back on the rvalid/rready response channel.
// No pulse is ever sent to a slot whose busy is high.
// Optional feature: define REG_CDC_SEQ_TIMEOUT_EN to bound the WAIT state to
// TimeoutCycles cycles. On expiry the response carries err = 1 and rdata = 0.

module reg_cdc_req_sequencer #(
  parameter int NumRegs       = 4,
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  input  logic                         we_i,
  input  logic [AddrWidth-1:0]         addr_i,
  input  logic [DataWidth-1:0]         wdata_i,
  output logic                         gnt_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [DataWidth-1:0]         rdata_o,
  output logic                         err_o,
  input  logic [NumRegs-1:0]           slot_regwen_i,
  input  logic [NumRegs-1:0]           slot_busy_i,
  input  logic [NumRegs*DataWidth-1:0] slot_qs_i,
  output logic [NumRegs-1:0]           slot_we_o,
  output logic [NumRegs-1:0]           slot_re_o,
  output logic                         slot_regwen_o,
  output logic [DataWidth-1:0]         slot_wd_o
);

  localparam int IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 we_q, we_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [IdxW-1:0]      reqIdx;
  logic                 addrInvalid;
  logic [DataWidth-1:0] targetQs;

`ifdef REG_CDC_SEQ_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Decode the request address; addresses beyond the last slot are rejected
  // without a pulse, and the read-back mux follows the captured slot.
  always_comb begin
    reqIdx      = addr_i[IdxW-1:0];
    addrInvalid = ({1'b0, addr_i} >= (AddrWidth+1)'(NumRegs));
    targetQs    = slot_qs_i[32'(idx_q)*DataWidth +: DataWidth];
  end

  // Request/response sequencing: grant, one-cycle pulse, wait on busy, respond.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gnt_o   = 1'b0;
`ifdef REG_CDC_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_i && (addrInvalid || !slot_busy_i[reqIdx])) begin
          gnt_o   = 1'b1;
          we_d    = we_i;
          idx_d   = reqIdx;
          wdata_d = wdata_i;
          if (addrInvalid) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef REG_CDC_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (!slot_busy_i[idx_q]) begin
          rdata_d = targetQs;
          err_d   = 1'b0;
          state_d = StResp;
        end
`ifdef REG_CDC_SEQ_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        if (rready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and capture registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef REG_CDC_SEQ_TIMEOUT_EN
  // WAIT-state timeout counter, cleared on every entry to WAIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Pulses exist only in ISSUE and target exactly the captured slot.
  always_comb begin
    slot_we_o     = '0;
    slot_re_o     = '0;
    slot_regwen_o = 1'b0;
    if (state_q == StIssue) begin
      slot_we_o[idx_q] = we_q;
      slot_re_o[idx_q] = ~we_q;
      slot_regwen_o    = slot_regwen_i[idx_q];
    end
  end

  assign rvalid_o  = (state_q == StResp);
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign slot_wd_o = wdata_q;

  a_no_pulse_to_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    ((slot_we_o | slot_re_o) & slot_busy_i) == '0);

  a_pulse_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(slot_we_o | slot_re_o));

  a_rvalid_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (rvalid_o && !rready_i) |=> (rvalid_o && $stable(rdata_o) && $stable(err_o)));

endmodule
